pc_step_counter: RTL and testbench
==================================

Name: pc_step_counter

Overview:
- Parametrised program-counter register; next generation of the fixed +2 incrementer.
- Holds the fetch address and advances it by a configurable power-of-two STEP each enabled cycle.
- Supports stall, redirect (load), halt/resume, alignment checking, wrap detection and a saturating advance counter.
- Sits at the head of the fetch stage and drives instruction-memory address and the sequential return address.

Parameters:
- WIDTH, 16, address width in bits (4..32).
- STEP, 2, increment per advance; power of two, 1 <= STEP < 2^WIDTH.
- RESET_VEC, 0, PC value after reset; must be STEP-aligned.
- CNT_WIDTH, 16, width of the advance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance PC by STEP this cycle.
- stall  in  1  hold PC; overrides en.
- load  in  1  redirect PC to load_addr; overrides stall and en.
- load_addr  in  WIDTH  redirect target.
- halt  in  1  enter HALTED state.
- resume  in  1  leave HALTED state.
- pc  out  WIDTH  current PC (registered).
- pc_seq  out  WIDTH  pc + STEP mod 2^WIDTH (combinational from pc).
- wrap  out  1  one-cycle pulse: last advance wrapped past 2^WIDTH-1.
- misalign  out  1  sticky; a load had non-zero low log2(STEP) bits.
- halted  out  1  high while in HALTED.
- adv_cnt  out  CNT_WIDTH  number of advances since reset, saturating.

Behaviour:
- Reset values:
  - pc = RESET_VEC, pc_seq = RESET_VEC + STEP.
  - wrap = 0, misalign = 0, halted = 0, adv_cnt = 0.
  - State = RUN.
- rst dominates every other input, including mid-halt and mid-load.
- States: RUN and HALTED.
  - RUN -> HALTED when halt = 1. The same cycle's load/en is ignored and pc holds.
  - HALTED -> RUN when resume = 1 and halt = 0. pc is unchanged on the resume cycle.
  - In HALTED, load, en and stall are ignored. pc, adv_cnt and misalign hold, and wrap = 0.
  - halt and resume asserted together: halt wins; the state is HALTED (or stays HALTED).
- RUN priority is load > stall > en.
  - load: pc <= load_addr with the low log2(STEP) bits forced to 0. If any of those bits were 1, misalign <= 1 (sticky until rst). adv_cnt unchanged; wrap <= 0.
  - stall (no load): pc holds, wrap <= 0, adv_cnt holds.
  - en (no load, no stall): pc <= pc_seq and adv_cnt <= adv_cnt + 1, saturating at 2^CNT_WIDTH - 1. wrap <= 1 iff pc + STEP carries out of bit WIDTH-1, otherwise 0.
  - No control input asserted: pc holds, wrap <= 0.
- Latency: one cycle from en/load to the new pc. pc_seq is valid in the same cycle as pc.
- Arithmetic:
  - Ripple or any adder, evaluated at WIDTH+1 bits.
  - The carry bit feeds wrap; the sum is truncated to WIDTH bits.
- With STEP = 1, no alignment bits exist and misalign never sets.
- Saturation: adv_cnt stays at its maximum once reached and never rolls over.

Test Plan:
- Reset/advance, WIDTH=16, STEP=2:
  - Reset, then en = 1 for 3 cycles gives pc = 0x0000 -> 0x0002 -> 0x0004 -> 0x0006.
  - adv_cnt = 3; pc_seq = 0x0008.
- Wrap:
  - load 0xFFFE, then en gives pc = 0x0000 with wrap = 1 for exactly one cycle.
  - A further en gives pc = 0x0002 with wrap = 0.
- Priority:
  - load = 1, stall = 1, en = 1, load_addr = 0x1234 gives pc = 0x1234 next cycle; adv_cnt unchanged.
  - stall = 1, en = 1 gives pc held.
- Misalign:
  - load_addr = 0x0101 with STEP=2 gives pc = 0x0100 and misalign = 1.
  - A later aligned load keeps misalign = 1; rst clears it.
- Halt/resume:
  - At pc = 0x0010, assert halt with en: pc stays 0x0010 and halted = 1.
  - load 0x2000 while halted has no effect.
  - resume gives halted = 0 with pc = 0x0010; the next en gives 0x0012.
  - halt and resume together while halted keeps halted = 1.
- Saturation/reset mid-op:
  - CNT_WIDTH=2: 5 advances give adv_cnt = 3.
  - rst asserted together with load gives pc = RESET_VEC and all flags 0.
  - Repeat the advance check with STEP=4, WIDTH=8: advances from 0x00 give 0x04, 0x08; load 0xFE gives 0xFC.

Source files
------------

// File: rtl/pc_step_counter.sv
// pc_step_counter: program-counter register for the head of the fetch stage.
// Advances the fetch address by a power-of-two STEP, supports stall, redirect,
// halt/resume, misaligned-redirect flagging, wrap detection and a saturating
// count of advances.
module pc_step_counter #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STEP      = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 stall,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_addr,
  input  logic                 halt,
  input  logic                 resume,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_seq,
  output logic                 wrap,
  output logic                 misalign,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] adv_cnt
);

  // STEP is a power of two, so STEP-1 selects exactly the alignment bits
  // (empty mask when STEP = 1, which keeps misalign permanently clear).
  localparam logic [WIDTH-1:0]     STEP_V     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0]     ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t         state;
  logic [WIDTH:0] sum_p0;

  // Saturating increment: the advance counter parks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage p0: sequential address, one bit wider so the carry-out is the wrap flag.
  assign sum_p0 = {1'b0, pc} + {1'b0, STEP_V};
  assign pc_seq = sum_p0[WIDTH-1:0];
  assign halted = (state == HALTED);

  // Stage p1: PC register, RUN/HALTED state and flags; rst beats every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_VEC;
      wrap     <= 1'b0;
      misalign <= 1'b0;
      adv_cnt  <= '0;
    end else begin
      // wrap is a single-cycle pulse; only an advance may raise it again.
      wrap <= 1'b0;
      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (load) begin
            pc <= load_addr & ~ALIGN_MASK;
            if (|(load_addr & ALIGN_MASK)) misalign <= 1'b1;
          end else if (!stall && en) begin
            pc      <= sum_p0[WIDTH-1:0];
            wrap    <= sum_p0[WIDTH];
            adv_cnt <= sat_inc(adv_cnt);
          end
        end
        HALTED: begin
          // halt asserted alongside resume keeps the core parked.
          if (resume && !halt) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_step_counter.sv
// tb_pc_step_counter: drives four differently-parameterised pc_step_counter
// instances from a shared stimulus stream and checks each against an
// arithmetic reference model, with directed checks for the key scenarios.
module tb_pc_step_counter;

  logic        clk;
  logic        rst, en, stall, load, halt, resume;
  logic [15:0] load_addr;

  logic [15:0] pc0, seq0, cnt0;
  logic [15:0] pc1, seq1;
  logic [1:0]  cnt1;
  logic [7:0]  pc2, seq2;
  logic [15:0] cnt2;
  logic [4:0]  pc3, seq3;
  logic [2:0]  cnt3;
  logic        wrap0, mis0, hlt0, wrap1, mis1, hlt1;
  logic        wrap2, mis2, hlt2, wrap3, mis3, hlt3;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instance parameters: width, step, reset vector, counter maximum.
  localparam int    PW[4] = '{16, 16, 8, 5};
  localparam int    PS[4] = '{2, 2, 4, 1};
  localparam int    PR[4] = '{0, 64, 0, 30};
  localparam longint PC[4] = '{65535, 3, 65535, 7};

  longint m_pc[4];
  longint m_cnt[4];
  bit     m_wrap[4], m_mis[4], m_halt[4];

  pc_step_counter #(.WIDTH(16), .STEP(2), .RESET_VEC(16'h0000), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .load(load), .load_addr(load_addr),
    .halt(halt), .resume(resume), .pc(pc0), .pc_seq(seq0), .wrap(wrap0),
    .misalign(mis0), .halted(hlt0), .adv_cnt(cnt0));

  pc_step_counter #(.WIDTH(16), .STEP(2), .RESET_VEC(16'h0040), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .load(load), .load_addr(load_addr),
    .halt(halt), .resume(resume), .pc(pc1), .pc_seq(seq1), .wrap(wrap1),
    .misalign(mis1), .halted(hlt1), .adv_cnt(cnt1));

  pc_step_counter #(.WIDTH(8), .STEP(4), .RESET_VEC(8'h00), .CNT_WIDTH(16)) u2 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .load(load), .load_addr(load_addr[7:0]),
    .halt(halt), .resume(resume), .pc(pc2), .pc_seq(seq2), .wrap(wrap2),
    .misalign(mis2), .halted(hlt2), .adv_cnt(cnt2));

  pc_step_counter #(.WIDTH(5), .STEP(1), .RESET_VEC(5'd30), .CNT_WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .load(load), .load_addr(load_addr[4:0]),
    .halt(halt), .resume(resume), .pc(pc3), .pc_seq(seq3), .wrap(wrap3),
    .misalign(mis3), .halted(hlt3), .adv_cnt(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular arithmetic following the behaviour rules.
  task automatic model_step(input bit r, e, s, l, input logic [15:0] a, input bit h, rs);
    longint m, aa;
    for (int i = 0; i < 4; i++) begin
      m = longint'(1) << PW[i];
      if (r) begin
        m_pc[i] = PR[i]; m_cnt[i] = 0;
        m_wrap[i] = 0; m_mis[i] = 0; m_halt[i] = 0;
      end else if (m_halt[i]) begin
        m_wrap[i] = 0;
        if (rs && !h) m_halt[i] = 0;
      end else if (h) begin
        m_halt[i] = 1; m_wrap[i] = 0;
      end else if (l) begin
        aa = longint'(a) % m;
        m_pc[i] = aa - (aa % PS[i]);
        if ((aa % PS[i]) != 0) m_mis[i] = 1;
        m_wrap[i] = 0;
      end else if (s || !e) begin
        m_wrap[i] = 0;
      end else begin
        m_wrap[i] = (m_pc[i] + PS[i]) >= m;
        m_pc[i]   = (m_pc[i] + PS[i]) % m;
        if (m_cnt[i] < PC[i]) m_cnt[i]++;
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] p, sq, w, ms, hl, c);
    longint m;
    m = longint'(1) << PW[i];
    check($sformatf("u%0d.pc", i),       p,  32'(m_pc[i]));
    check($sformatf("u%0d.pc_seq", i),   sq, 32'((m_pc[i] + PS[i]) % m));
    check($sformatf("u%0d.wrap", i),     w,  32'(m_wrap[i]));
    check($sformatf("u%0d.misalign", i), ms, 32'(m_mis[i]));
    check($sformatf("u%0d.halted", i),   hl, 32'(m_halt[i]));
    check($sformatf("u%0d.adv_cnt", i),  c,  32'(m_cnt[i]));
  endtask

  task automatic tick(input bit r, e, s, l, input logic [15:0] a, input bit h, rs);
    rst = r; en = e; stall = s; load = l; load_addr = a; halt = h; resume = rs;
    @(posedge clk);
    model_step(r, e, s, l, a, h, rs);
    #1;
    cmp_inst(0, 32'(pc0), 32'(seq0), 32'(wrap0), 32'(mis0), 32'(hlt0), 32'(cnt0));
    cmp_inst(1, 32'(pc1), 32'(seq1), 32'(wrap1), 32'(mis1), 32'(hlt1), 32'(cnt1));
    cmp_inst(2, 32'(pc2), 32'(seq2), 32'(wrap2), 32'(mis2), 32'(hlt2), 32'(cnt2));
    cmp_inst(3, 32'(pc3), 32'(seq3), 32'(wrap3), 32'(mis3), 32'(hlt3), 32'(cnt3));
  endtask

  initial begin
    logic [15:0] cnt_before;
    bit r, e, s, l, h, rs;

    // Reset state
    tick(1, 0, 0, 0, 16'h0, 0, 0);
    check("rst_pc", 32'(pc0), 32'h0);
    check("rst_seq", 32'(seq0), 32'h2);
    check("rst_flags", 32'({wrap0, mis0, hlt0}), 32'h0);
    check("rst_cnt", 32'(cnt0), 32'h0);
    check("rst_pc_u1", 32'(pc1), 32'h40);

    // Basic advance
    tick(0, 1, 0, 0, 16'h0, 0, 0);
    check("adv1_pc", 32'(pc0), 32'h2);
    check("adv1_pc_w8s4", 32'(pc2), 32'h04);
    tick(0, 1, 0, 0, 16'h0, 0, 0);
    check("adv2_pc_w8s4", 32'(pc2), 32'h08);
    tick(0, 1, 0, 0, 16'h0, 0, 0);
    check("adv3_pc", 32'(pc0), 32'h6);
    check("adv3_cnt", 32'(cnt0), 32'd3);
    check("adv3_seq", 32'(seq0), 32'h8);

    // Wrap
    tick(0, 0, 0, 1, 16'hFFFE, 0, 0);
    check("load_fffe", 32'(pc0), 32'hFFFE);
    check("load_fe_w8s4", 32'(pc2), 32'hFC);
    check("mis_fe_w8s4", 32'(mis2), 32'h1);
    tick(0, 1, 0, 0, 16'h0, 0, 0);
    check("wrap_pc", 32'(pc0), 32'h0);
    check("wrap_pulse", 32'(wrap0), 32'h1);
    tick(0, 1, 0, 0, 16'h0, 0, 0);
    check("after_wrap_pc", 32'(pc0), 32'h2);
    check("after_wrap_flag", 32'(wrap0), 32'h0);
    check("sat_cnt2", 32'(cnt1), 32'd3);

    // Priority
    cnt_before = cnt0;
    tick(0, 1, 1, 1, 16'h1234, 0, 0);
    check("prio_load_pc", 32'(pc0), 32'h1234);
    check("prio_load_cnt", 32'(cnt0), 32'(cnt_before));
    tick(0, 1, 1, 0, 16'h0, 0, 0);
    check("stall_hold", 32'(pc0), 32'h1234);

    // Misalign
    tick(0, 0, 0, 1, 16'h0101, 0, 0);
    check("mis_pc", 32'(pc0), 32'h0100);
    check("mis_set", 32'(mis0), 32'h1);
    tick(0, 0, 0, 1, 16'h0200, 0, 0);
    check("mis_sticky", 32'(mis0), 32'h1);
    tick(1, 0, 0, 0, 16'h0, 0, 0);
    check("mis_rst", 32'(mis0), 32'h0);

    // Halt / resume
    tick(0, 0, 0, 1, 16'h0010, 0, 0);
    tick(0, 1, 0, 0, 16'h0, 1, 0);
    check("halt_pc", 32'(pc0), 32'h0010);
    check("halt_flag", 32'(hlt0), 32'h1);
    tick(0, 0, 0, 1, 16'h2000, 0, 0);
    check("halt_load_ign", 32'(pc0), 32'h0010);
    tick(0, 0, 0, 0, 16'h0, 0, 1);
    check("resume_flag", 32'(hlt0), 32'h0);
    check("resume_pc", 32'(pc0), 32'h0010);
    tick(0, 1, 0, 0, 16'h0, 0, 0);
    check("resume_adv", 32'(pc0), 32'h0012);
    tick(0, 0, 0, 0, 16'h0, 1, 0);
    tick(0, 0, 0, 0, 16'h0, 1, 1);
    check("halt_resume_both", 32'(hlt0), 32'h1);
    tick(0, 0, 0, 0, 16'h0, 0, 1);

    // Reset dominating a load
    tick(0, 0, 0, 1, 16'h0101, 0, 0);
    tick(1, 1, 0, 1, 16'h3333, 0, 0);
    check("rstload_pc", 32'(pc0), 32'h0);
    check("rstload_pc_u1", 32'(pc1), 32'h40);
    check("rstload_flags", 32'({wrap0, mis0, hlt0}), 32'h0);
    check("rstload_cnt", 32'(cnt0), 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 63) == 0);
      e  = ($urandom_range(0, 1) == 1);
      s  = ($urandom_range(0, 5) == 0);
      l  = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 4) == 0);
      tick(r, e, s, l, 16'($urandom), h, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
